// File: rtl/fir_mac_ctrl.sv
// Time-multiplexed FIR engine: circular sample delay line plus TAPS MAC cycles per
// accepted sample over externally instantiated sample/coefficient RAMs (1-cycle read).
module fir_mac_ctrl #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 18,
  parameter int ADDR_W = 9,
  parameter int TAPS   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              smp_we,
  output logic [ADDR_W-1:0] smp_addr,
  output logic [DATA_W-1:0] smp_din,
  input  logic [DATA_W-1:0] smp_dout,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + ADDR_W;
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADDR_W-1:0]         r_wptr;
  logic [ADDR_W-1:0]         r_k;
  logic                      r_drain;
  logic                      r_rd_vld;
  logic                      r_prod_vld;
  logic signed [PROD_W-1:0]  r_prod;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      w_accept;
  logic signed [DATA_W-1:0]  w_smp;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [ACC_W-1:0]   w_rnd;
  logic signed [ACC_W-1:0]   w_shf;
  logic [DATA_W-1:0]         w_sat;

  assign w_smp  = smp_dout;
  assign w_coef = coef_dout;
  assign w_rnd  = r_acc + RND;
  assign w_shf  = w_rnd >>> (COEF_W - 1);

  // Clamp the rounded accumulator into the output sample range.
  always_comb begin
    w_sat = w_shf[DATA_W-1:0];
    if (w_shf > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_shf < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end else begin
      w_sat = w_shf[DATA_W-1:0];
    end
  end

  // Next-state and RAM-port decode; RAM strobes are forced quiet while rst is high.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    smp_we      = 1'b0;
    smp_addr    = '0;
    smp_din     = '0;
    coef_addr   = '0;
    if (rst) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          in_ready = 1'b1;
          smp_addr = r_wptr;
          if (in_valid) begin
            w_accept    = 1'b1;
            smp_we      = 1'b1;
            smp_din     = in_data;
            w_state_nxt = S_MAC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_MAC: begin
          busy      = 1'b1;
          smp_addr  = r_wptr - r_k;
          coef_addr = r_k;
          if (r_k == K_LAST) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_MAC;
          end
        end
        S_DRAIN: begin
          busy = 1'b1;
          if (r_drain) begin
            w_state_nxt = S_OUT;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_OUT: begin
          busy        = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State register, tap counter and two-cycle drain timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
      if (w_accept) begin
        r_k <= '0;
      end else if (r_state == S_MAC) begin
        r_k <= r_k + 1'b1;
      end else begin
        r_k <= r_k;
      end
    end
  end

  // MAC pipeline: read-data valid one cycle after a MAC address, product one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld   <= 1'b0;
      r_prod_vld <= 1'b0;
      r_prod     <= '0;
      r_acc      <= '0;
    end else begin
      r_rd_vld   <= (r_state == S_MAC);
      r_prod_vld <= r_rd_vld;
      if (r_rd_vld) begin
        r_prod <= PROD_W'(w_smp) * PROD_W'(w_coef);
      end else begin
        r_prod <= r_prod;
      end
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_prod_vld) begin
        r_acc <= r_acc + {{ADDR_W{r_prod[PROD_W-1]}}, r_prod};
      end else begin
        r_acc <= r_acc;
      end
    end
  end

  // Output register and delay-line write pointer advance at the end of OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (r_state == S_OUT);
      if (r_state == S_OUT) begin
        out_data <= w_sat;
        r_wptr   <= r_wptr + 1'b1;
      end else begin
        out_data <= out_data;
        r_wptr   <= r_wptr;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Self-checking bench: two engines (TAPS=4 and TAPS=8, 8-deep delay line) with
// behavioural RAMs, checked against a circular-buffer convolution model.
module tb_fir_mac_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic in_valid;
  logic signed [23:0] in_data;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic va, rdy_a, we_a, ov_a, busy_a;
  logic [2:0] sa_a, ca_a;
  logic [23:0] sdin_a, sdout_a, od_a;
  logic [17:0] cdout_a;
  logic vb, rdy_b, we_b, ov_b, busy_b;
  logic [2:0] sa_b, ca_b;
  logic [23:0] sdin_b, sdout_b, od_b;
  logic [17:0] cdout_b;

  assign va = in_valid & ~sel;
  assign vb = in_valid & sel;

  fir_mac_ctrl #(.DATA_W(24), .COEF_W(18), .ADDR_W(3), .TAPS(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_data(in_data), .in_ready(rdy_a),
    .smp_we(we_a), .smp_addr(sa_a), .smp_din(sdin_a), .smp_dout(sdout_a),
    .coef_addr(ca_a), .coef_dout(cdout_a), .out_valid(ov_a), .out_data(od_a),
    .busy(busy_a));

  fir_mac_ctrl #(.DATA_W(24), .COEF_W(18), .ADDR_W(3), .TAPS(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_data(in_data), .in_ready(rdy_b),
    .smp_we(we_b), .smp_addr(sa_b), .smp_din(sdin_b), .smp_dout(sdout_b),
    .coef_addr(ca_b), .coef_dout(cdout_b), .out_valid(ov_b), .out_data(od_b),
    .busy(busy_b));

  // Behavioural RAMs with registered read data.
  logic [23:0] smem_a [8] = '{default: 24'd0};
  logic [23:0] smem_b [8] = '{default: 24'd0};
  logic signed [17:0] coef [2][8];

  always @(posedge clk) begin
    if (we_a) smem_a[sa_a] <= sdin_a;
    sdout_a <= smem_a[sa_a];
    cdout_a <= coef[0][ca_a];
    if (we_b) smem_b[sa_b] <= sdin_b;
    sdout_b <= smem_b[sa_b];
    cdout_b <= coef[1][ca_b];
  end

  logic rdy_s, we_s, ov_s, busy_s;
  logic [2:0] addr_s;
  logic signed [23:0] od_s;
  assign rdy_s  = sel ? rdy_b  : rdy_a;
  assign we_s   = sel ? we_b   : we_a;
  assign ov_s   = sel ? ov_b   : ov_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign addr_s = sel ? sa_b   : sa_a;
  assign od_s   = sel ? od_b   : od_a;

  // Reference model: delay line contents and write pointer per engine.
  longint mram [2][8];
  int mwptr [2];

  function automatic logic signed [23:0] model_push(input logic signed [23:0] d);
    longint acc;
    longint r;
    int taps;
    taps = sel ? 8 : 4;
    mram[sel][mwptr[sel]] = longint'(d);
    acc = 0;
    for (int k = 0; k < taps; k++)
      acc += mram[sel][(mwptr[sel] - k) & 7] * longint'(coef[sel][k]);
    mwptr[sel] = (mwptr[sel] + 1) % 8;
    r = (acc + 65536) >>> 17;
    if (r > 8388607) r = 8388607;
    else if (r < -8388608) r = -8388608;
    return 24'(r);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rdy_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", rdy_s, 1);
  endtask

  task automatic send(input logic signed [23:0] d, output logic signed [23:0] got);
    logic signed [23:0] exp_v;
    int n;
    int viol;
    int taps;
    taps = sel ? 8 : 4;
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("accept_we", we_s, 1);
    chk("accept_addr", addr_s, mwptr[sel]);
    exp_v = model_push(d);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    viol = 0;
    while (!ov_s && n < taps + 10) begin
      if (rdy_s || !busy_s) viol++;
      @(negedge clk);
      n++;
    end
    chk("latency", n, taps + 4);
    chk("busy_not_ready", viol, 0);
    chk("out_data", od_s, exp_v);
    got = od_s;
    @(negedge clk);
    chk("pulse_single", ov_s, 0);
    chk("out_hold", od_s, exp_v);
  endtask

  logic signed [23:0] got;
  int acc_c[$];
  int ov_c[$];
  logic signed [23:0] expq[$];
  int viol;
  int nacc;

  initial begin
    sel = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mwptr[i] = 0;
      for (int j = 0; j < 8; j++) begin
        mram[i][j] = 0;
        coef[i][j] = '0;
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", rdy_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_data", od_a, 0);
    chk("rst_smp_we", we_a, 0);
    chk("rst_smp_addr", sa_a, 0);
    chk("rst_coef_addr", ca_a, 0);
    @(negedge clk);

    // Impulse response
    coef[0][0] = 18'sd65536; coef[0][1] = 18'sd32768;
    coef[0][2] = -18'sd32768; coef[0][3] = 18'sd16384;
    send(24'sd1000, got); chk("impulse0", got, 500);
    send(24'sd0, got);    chk("impulse1", got, 250);
    send(24'sd0, got);    chk("impulse2", got, -250);
    send(24'sd0, got);    chk("impulse3", got, 125);
    send(24'sd0, got);    chk("impulse4", got, 0);

    // Round half up
    coef[0][1] = '0; coef[0][2] = '0; coef[0][3] = '0;
    send(24'sd3, got);  chk("round_pos", got, 2);
    send(-24'sd3, got); chk("round_neg", got, -1);

    // Saturation both rails
    for (int k = 0; k < 4; k++) coef[0][k] = 18'sd131071;
    for (int i = 0; i < 4; i++) send(24'sd8388607, got);
    chk("sat_pos", got, 8388607);
    for (int i = 0; i < 4; i++) send(-24'sd8388608, got);
    chk("sat_neg", got, -8388608);

    // Backpressure: in_valid held high, new random sample after each accept
    for (int k = 0; k < 4; k++) coef[0][k] = 18'($urandom);
    wait_ready();
    in_valid = 1'b1;
    in_data = 24'($urandom);
    nacc = 0;
    viol = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (ov_s) begin
        ov_c.push_back(cyc);
        if (expq.size() > 0) chk("bp_data", od_s, expq.pop_front());
        else chk("bp_spurious_out", ov_s, 0);
      end
      if (rdy_s == busy_s) viol++;
      if (in_valid && rdy_s) begin
        acc_c.push_back(cyc);
        expq.push_back(model_push(in_data));
        nacc++;
      end
      #1;
      if (acc_c.size() > 0 && acc_c[$] == cyc) begin
        @(posedge clk);
        #1;
        in_data = 24'($urandom);
        if (nacc == 5) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc_c.size(), 5);
    chk("bp_outputs", ov_c.size(), 5);
    chk("bp_ready_vs_busy", viol, 0);
    for (int i = 1; i < acc_c.size(); i++) chk("bp_interval", acc_c[i] - acc_c[i-1], 8);
    for (int i = 0; i < ov_c.size() && i < acc_c.size(); i++)
      chk("bp_latency", ov_c[i] - acc_c[i], 8);

    // Reset in the middle of MAC
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    in_data = 24'sd777;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mram[0][mwptr[0]] = 777;
    mwptr[0] = 0;
    mwptr[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", rdy_a, 1);
    chk("abort_busy", busy_a, 0);
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov_a) viol++;
    end
    chk("abort_no_out", viol, 0);
    send(24'sd1234, got);

    // Wrap-around on the TAPS=8 engine with a signed ramp and random coefficients
    sel = 1'b1;
    for (int k = 0; k < 8; k++) coef[1][k] = 18'($urandom);
    @(negedge clk);
    for (int i = 0; i < 40; i++) send(24'(-4000000 + i * 200000), got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_mac_ctrl.md
# fir_mac_ctrl

Time-multiplexed FIR engine that sits between the audio sample source and two dual-port block RAMs: the sample delay line and the coefficient store. Per accepted input sample it writes the sample into a circular delay line and runs TAPS multiply-accumulate cycles over the sample and coefficient RAMs. It then rounds and saturates the result and emits one output sample. The RAMs are external instances with registered read data (1-cycle read latency).

## Interface
- DATA_W, 24, sample width (signed), also sample RAM data width
- COEF_W, 18, coefficient width (signed, Q1.(COEF_W-1))
- ADDR_W, 9, RAM address width; delay line depth 2**ADDR_W
- TAPS, 256, filter length; legal range 1..2**ADDR_W
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_data  in  DATA_W  input sample
- in_ready  out  1  high only in IDLE
- smp_we  out  1  sample RAM write enable
- smp_addr  out  ADDR_W  sample RAM address
- smp_din  out  DATA_W  sample RAM write data
- smp_dout  in  DATA_W  sample RAM read data, valid 1 cycle after address
- coef_addr  out  ADDR_W  coefficient RAM read address
- coef_dout  in  COEF_W  coefficient RAM read data, valid 1 cycle after address
- out_valid  out  1  one-cycle pulse, out_data valid
- out_data  out  DATA_W  filtered sample, registered
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, MAC, DRAIN, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: drive smp_we=1, smp_addr=wptr, smp_din=in_data; clear acc; k=0; go to MAC.
  - in_valid while not in IDLE is ignored; the source holds the sample.
- MAC, TAPS cycles, k=0..TAPS-1:
  - smp_addr=(wptr-k) mod 2**ADDR_W; coef_addr=k; smp_we=0.
  - After k=TAPS-1, go to DRAIN.
- Datapath pipeline:
  - Read data returns 1 cycle after the address.
  - prod = smp_dout*coef_dout, signed, full width DATA_W+COEF_W, registered.
  - acc += prod one cycle later.
  - acc width is DATA_W+COEF_W+ADDR_W, so no internal overflow is possible.
- DRAIN: 2 cycles, to flush the read and product stages; no RAM access.
- OUT: 1 cycle.
  - r = (acc + 2**(COEF_W-2)) >>> (COEF_W-1): round half up, arithmetic shift.
  - Saturate r to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
  - Register into out_data and set out_valid for the next cycle.
  - wptr = wptr+1 mod 2**ADDR_W; go to IDLE.
- The k=0 read hits the sample written in the accept cycle; the RAM write completes at that edge, so no bypass is needed.
- Wrap-around: wptr and the sample address wrap modulo 2**ADDR_W. The delay line starts as all-zero RAM, so start-up output equals zero-padded convolution.
- Reset:
  - State=IDLE, wptr=0, acc=0, prod=0, k=0.
  - out_valid=0, out_data=0, smp_we=0, smp_addr=0, smp_din=0, coef_addr=0.
  - in_ready=1 and busy=0 from the first cycle after rst deasserts.
  - Reset mid-operation aborts the sample: no out_valid; RAM contents are untouched.

## Timing
- Accept in cycle T, i.e. the in_valid&in_ready edge.
- T+1..T+TAPS: MAC. T+TAPS+1..T+TAPS+2: DRAIN. T+TAPS+3: OUT.
- out_valid high exactly in cycle T+TAPS+4, which is IDLE again. Latency is TAPS+4 cycles.
- in_ready is high in T+TAPS+4, so the next accept can occur there. Max throughput is 1 sample per TAPS+4 cycles.
- out_data holds its value until the next OUT. out_valid is never high for 2 consecutive cycles.

## Test plan
- Impulse: TAPS=4, coefs {65536, 32768, -32768, 16384}, input 1000 followed by zeros -> outputs 500, 250, -250, 125, 0.
- Rounding/saturation, rounding part: coef0=65536, others 0; inputs 3, -3 -> 2, -1.
- Rounding/saturation, saturation part: all coefs 131071; four inputs of 8388607 -> 4th output 8388607. Repeat with -8388608 -> -8388608.
- Wrap: ADDR_W=3, TAPS=8, 40-sample signed ramp with random coefs -> bit-exact match to the golden model across 5 wptr wraps.
- Backpressure: TAPS=4, in_valid held high with a new sample each accept -> exactly one accept every 8 cycles. out_valid 8 cycles after each accept. in_ready=0 whenever busy=1.
- Reset mid-MAC: rst asserted in cycle T+2 for 1 cycle -> no out_valid, wptr=0, in_ready=1 the cycle after rst drops. The next sample is written at address 0.
